// File: rtl/flit_mux2_pkg.sv
// flit_mux2_pkg: shared widths, flit type codes, level names and the
// internal flit bundle used by the two-input flit multiplexer.
package flit_mux2_pkg;

    // Datapath widths
    localparam int DATA_W = 66;   // flit width, top TYPE_W bits are the type
    localparam int VCH_W  = 2;    // virtual-channel id width
    localparam int SEL_W  = 5;    // router port-select width, only [1:0] decoded
    localparam int TYPE_W = 2;
    localparam int NUM_IN = 2;    // inputs handled by this mux

    // Flit type codes carried in data[DATA_W-1 -: TYPE_W]; passed through untouched
    typedef enum logic [TYPE_W-1:0] {
        TYPE_NONE = 2'b00,
        TYPE_HEAD = 2'b01,
        TYPE_DATA = 2'b10,
        TYPE_TAIL = 2'b11
    } flit_type_e;

    // Level names
    localparam logic High     = 1'b1;
    localparam logic Low      = 1'b0;
    localparam logic Enable   = 1'b1;
    localparam logic Disable  = 1'b0;
    localparam logic Enable_  = 1'b0;   // active-low enable asserted
    localparam logic Disable_ = 1'b1;   // active-low enable deasserted

    // One input's flit as seen by the mux
    typedef struct packed {
        logic             vld;
        logic [VCH_W-1:0] vch;
        logic [DATA_W-1:0] data;
    } flit_t;

endpackage

// File: rtl/flit_sel_dec.sv
// flit_sel_dec: one-hot port select to grant, lowest input wins when
// several select bits are set.
module flit_sel_dec
    import flit_mux2_pkg::*;
(
    input  logic [NUM_IN-1:0] sel_lo,
    output logic [NUM_IN-1:0] gnt
);

    genvar i;
    generate
        for (i = 0; i < NUM_IN; i++) begin : g_gnt
            if (i == 0) begin : g_first
                assign gnt[i] = sel_lo[0];
            end else begin : g_rest
                // masked by any lower-numbered request
                assign gnt[i] = sel_lo[i] & ~(|sel_lo[i-1:0]);
            end
        end
    endgenerate

endmodule

// File: rtl/flit_mux2.sv
// flit_mux2: two-input flit multiplexer with a registered output.
// ovalid follows the selected input's valid every cycle; odata/ovch are
// clock-enabled by that valid so an idle output does not toggle.
// Optional build macro MUX_SEL_CHECK_EN adds a sticky sel_err output.
module flit_mux2
    import flit_mux2_pkg::*;
(
    input  logic              clk,
    input  logic              rst_,
    input  logic [DATA_W-1:0] idata_0,
    input  logic              ivalid_0,
    input  logic [VCH_W-1:0]  ivch_0,
    input  logic [DATA_W-1:0] idata_1,
    input  logic              ivalid_1,
    input  logic [VCH_W-1:0]  ivch_1,
    input  logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] odata,
    output logic              ovalid,
    output logic [VCH_W-1:0]  ovch
`ifdef MUX_SEL_CHECK_EN
    ,
    output logic              sel_err
`endif
);

    localparam int STAGES = 1;

    flit_t [NUM_IN-1:0] in_flit;
    flit_t [NUM_IN-1:0] lane_flit;
    flit_t              sel_flit;
    logic  [NUM_IN-1:0] gnt;
    logic  [STAGES-1:0] vld_pipe;

    assign in_flit[0] = {ivalid_0, ivch_0, idata_0};
    assign in_flit[1] = {ivalid_1, ivch_1, idata_1};

    flit_sel_dec u_dec (
        .sel_lo (sel[NUM_IN-1:0]),
        .gnt    (gnt)
    );

    // Grant is one-hot or zero, so an AND-OR mux is enough
    genvar i;
    generate
        for (i = 0; i < NUM_IN; i++) begin : g_lane
            assign lane_flit[i] = gnt[i] ? in_flit[i] : '0;
        end
    endgenerate

    // Collapse the gated lanes into the selected flit
    always_comb begin
        sel_flit = '0;
        for (int l = 0; l < NUM_IN; l++) begin
            sel_flit = flit_t'(sel_flit | lane_flit[l]);
        end
    end

    // Valid pipeline: clears on reset, always loads (zero when nothing selected)
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= sel_flit.vld;
            for (int s = 1; s < STAGES; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
            end
        end
    end

    assign ovalid = vld_pipe[STAGES-1];

    // Payload register: only loads on a valid selected flit, holds otherwise
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            odata <= '0;
            ovch  <= '0;
        end else if (sel_flit.vld == Enable) begin
            odata <= sel_flit.data;
            ovch  <= sel_flit.vch;
        end
    end

`ifdef MUX_SEL_CHECK_EN
    logic sel_bad;

    // Both decoded bits set, or an out-of-range port requested while traffic is live
    assign sel_bad = (&sel[NUM_IN-1:0]) |
                     ((|sel[SEL_W-1:NUM_IN]) & (ivalid_0 | ivalid_1));

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            sel_err <= Low;
        end else if (sel_bad) begin
            sel_err <= High;
        end
    end
`else
    // Upper select bits belong to other router ports and are not decoded here
    logic sel_hi_unused;
    assign sel_hi_unused = |sel[SEL_W-1:NUM_IN];
`endif

endmodule

// File: tb/tb_flit_mux2.sv
// tb_flit_mux2: table-driven directed check of flit_mux2 plus hand-written
// reset sequences. Define MUX_SEL_CHECK_EN to also cover sel_err.
module tb_flit_mux2;
    import flit_mux2_pkg::*;

    logic              clk = 1'b0;
    logic              rst_ = 1'b0;
    logic [DATA_W-1:0] idata_0 = '0, idata_1 = '0;
    logic              ivalid_0 = 1'b0, ivalid_1 = 1'b0;
    logic [VCH_W-1:0]  ivch_0 = '0, ivch_1 = '0;
    logic [SEL_W-1:0]  sel = '0;
    logic [DATA_W-1:0] odata;
    logic              ovalid;
    logic [VCH_W-1:0]  ovch;
`ifdef MUX_SEL_CHECK_EN
    logic              sel_err;
`endif

    flit_mux2 dut (
        .clk      (clk),
        .rst_     (rst_),
        .idata_0  (idata_0),
        .ivalid_0 (ivalid_0),
        .ivch_0   (ivch_0),
        .idata_1  (idata_1),
        .ivalid_1 (ivalid_1),
        .ivch_1   (ivch_1),
        .sel      (sel),
        .odata    (odata),
        .ovalid   (ovalid),
        .ovch     (ovch)
`ifdef MUX_SEL_CHECK_EN
        ,
        .sel_err  (sel_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SEL_W-1:0]  sel;
        logic              v0;
        logic [DATA_W-1:0] d0;
        logic [VCH_W-1:0]  c0;
        logic              v1;
        logic [DATA_W-1:0] d1;
        logic [VCH_W-1:0]  c1;
        logic              ev;
        logic [DATA_W-1:0] ed;
        logic [VCH_W-1:0]  ec;
        logic              ee;
    } vec_t;

    vec_t vecs[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic push(input logic [SEL_W-1:0] s,
                        input logic v0, input logic [DATA_W-1:0] d0, input logic [VCH_W-1:0] c0,
                        input logic v1, input logic [DATA_W-1:0] d1, input logic [VCH_W-1:0] c1,
                        input logic ev, input logic [DATA_W-1:0] ed, input logic [VCH_W-1:0] ec,
                        input logic ee);
        vec_t v;
        v.sel = s; v.v0 = v0; v.d0 = d0; v.c0 = c0;
        v.v1 = v1; v.d1 = d1; v.c1 = c1;
        v.ev = ev; v.ed = ed; v.ec = ec; v.ee = ee;
        vecs.push_back(v);
    endtask

    function automatic logic [DATA_W-1:0] rnd_flit();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[DATA_W-1:0];
    endfunction

    initial begin
        logic [63:0]       pat [10];
        logic [DATA_W-1:0] flit, junk, tail, d_rst, y1, z, a, b, c;
        logic [VCH_W-1:0]  rc;

        pat = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hCCCC_CCCC_CCCC_CCCC,
                64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
                64'hFFFF_0000_FFFF_0000, 64'hFFFF_FFFF_0000_0000,
                64'h8888_8888_8888_8888, 64'hEEEE_EEEE_EEEE_EEEE,
                64'h3C3C_3C3C_3C3C_3C3C, 64'h0F0F_0F0F_0F0F_0F0F};
        tail  = {TYPE_TAIL, 64'hDEAD_BEEF_0000_0014};
        d_rst = {TYPE_HEAD, 64'h1234_5678_9ABC_DEF0};
        y1    = {TYPE_HEAD, 64'h0000_1111_2222_3333};
        z     = {TYPE_DATA, 64'h7777_0000_7777_0000};
        a     = {TYPE_DATA, 64'hA5A5_A5A5_5A5A_5A5A};
        b     = {TYPE_TAIL, 64'h0123_4567_89AB_CDEF};
        c     = {TYPE_HEAD, 64'h0000_0000_0000_0C0C};

        // 22-flit packet on input 1 while input 0 carries valid traffic that must not leak
        for (int i = 0; i < 22; i++) begin
            if (i == 0)       flit = {TYPE_HEAD, 64'h0000_0000_0000_0009};
            else if (i == 21) flit = tail;
            else flit = {TYPE_DATA, ((i % 2) == 1) ? pat[(i-1)/2] : ~pat[(i-1)/2]};
            junk = {TYPE_DATA, 64'h5555_5555_5555_5500} ^ DATA_W'(i);
            push(5'b00010, 1'b1, junk, 2'd3, 1'b1, flit, 2'd1, 1'b1, flit, 2'd1, 1'b0);
        end
        // idle on input 1: output valid drops, data/vch keep the tail
        push(5'b00010, 1'b1, junk, 2'd3, 1'b0, {TYPE_NONE, 64'h0}, 2'd0, 1'b0, tail, 2'd1, 1'b0);
        push(5'b00010, 1'b0, '0,   2'd0, 1'b0, {TYPE_NONE, 64'h0}, 2'd0, 1'b0, tail, 2'd1, 1'b0);
        // input 0 with random traffic on both sides
        for (int i = 0; i < 6; i++) begin
            flit = rnd_flit();
            rc   = VCH_W'($urandom_range(0, 3));
            push(5'b00001, 1'b1, flit, rc, 1'b1, rnd_flit(), VCH_W'($urandom_range(0, 3)),
                 1'b1, flit, rc, 1'b0);
        end
        // source switch 01 -> 10 between consecutive edges, no bubble
        push(5'b00010, 1'b1, a, 2'd2, 1'b1, y1, 2'd1, 1'b1, y1, 2'd1, 1'b0);
        // selected input invalid while the other is valid: hold
        push(5'b00001, 1'b0, a, 2'd2, 1'b1, z, 2'd2, 1'b0, y1, 2'd1, 1'b0);
        // nothing selected
        push(5'b00000, 1'b1, a, 2'd2, 1'b1, z, 2'd2, 1'b0, y1, 2'd1, 1'b0);
        // both selected: input 0 wins, error flag sets
        push(5'b00011, 1'b1, a, 2'd0, 1'b1, z, 2'd3, 1'b1, a, 2'd0, 1'b1);
        // only undecoded bits set: behaves as no selection
        push(5'b11100, 1'b1, z, 2'd1, 1'b1, z, 2'd2, 1'b0, a, 2'd0, 1'b1);
        // upper bits ignored, input 1 forwarded
        push(5'b10010, 1'b1, z, 2'd1, 1'b1, b, 2'd3, 1'b1, b, 2'd3, 1'b1);

        // reset held with both inputs valid
        sel = 5'b00001; ivalid_0 = 1'b1; idata_0 = d_rst; ivch_0 = 2'd2;
        ivalid_1 = 1'b1; idata_1 = tail; ivch_1 = 2'd3; rst_ = 1'b0;
        #1;
        chk("rst_imm_valid", DATA_W'(ovalid), '0);
        chk("rst_imm_data", odata, '0);
        chk("rst_imm_vch", DATA_W'(ovch), '0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_valid", DATA_W'(ovalid), '0);
        chk("rst_hold_data", odata, '0);
        chk("rst_hold_vch", DATA_W'(ovch), '0);
`ifdef MUX_SEL_CHECK_EN
        chk("rst_hold_err", DATA_W'(sel_err), '0);
`endif
        @(negedge clk); rst_ = 1'b1;
        @(posedge clk); #1;
        chk("rel_valid", DATA_W'(ovalid), DATA_W'(1));
        chk("rel_data", odata, d_rst);
        chk("rel_vch", DATA_W'(ovch), DATA_W'(2));

        foreach (vecs[i]) begin
            @(negedge clk);
            sel = vecs[i].sel;
            ivalid_0 = vecs[i].v0; idata_0 = vecs[i].d0; ivch_0 = vecs[i].c0;
            ivalid_1 = vecs[i].v1; idata_1 = vecs[i].d1; ivch_1 = vecs[i].c1;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_valid", i), DATA_W'(ovalid), DATA_W'(vecs[i].ev));
            chk($sformatf("vec%0d_data", i), odata, vecs[i].ed);
            chk($sformatf("vec%0d_vch", i), DATA_W'(ovch), DATA_W'(vecs[i].ec));
`ifdef MUX_SEL_CHECK_EN
            chk($sformatf("vec%0d_err", i), DATA_W'(sel_err), DATA_W'(vecs[i].ee));
`endif
        end

        // reset mid-packet: outputs clear at once, forwarding resumes after release
        @(negedge clk);
        sel = 5'b00001; ivalid_0 = 1'b1; idata_0 = c; ivch_0 = 2'd1;
        ivalid_1 = 1'b0;
        rst_ = 1'b0;
        #1;
        chk("mid_rst_valid", DATA_W'(ovalid), '0);
        chk("mid_rst_data", odata, '0);
        chk("mid_rst_vch", DATA_W'(ovch), '0);
`ifdef MUX_SEL_CHECK_EN
        chk("mid_rst_err", DATA_W'(sel_err), '0);
`endif
        @(posedge clk); #1;
        chk("mid_rst_edge_data", odata, '0);
        @(negedge clk); rst_ = 1'b1;
        @(posedge clk); #1;
        chk("mid_rel_valid", DATA_W'(ovalid), DATA_W'(1));
        chk("mid_rel_data", odata, c);
        chk("mid_rel_vch", DATA_W'(ovch), DATA_W'(1));
`ifdef MUX_SEL_CHECK_EN
        chk("mid_rel_err", DATA_W'(sel_err), '0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
